// File: rtl/cayde_pkg.sv
// Shared decode/ALU types: ALU op encoding, RV32I opcode constants, registered decode bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cayde_pkg;

   // ALU_ADD must stay at encoding 0: it is the reset and illegal-bundle value.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_op_e     alu_op;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [31:0] imm;
      logic        sel_imm;
      logic        sel_pc;
      logic        sel_zero;
      logic        we;
      logic        illegal;
      logic [31:0] pc;
   } dec_bundle_t;

   // funct3 -> op for the funct7=0 / non-alternate encodings shared by OP and OP-IMM.
   function automatic alu_op_e f3_to_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/cayde_imm_gen.sv
// Immediate generator: I-type sign-extend, shift shamt, U-type upper, chosen by opcode.
// Latency: combinational.
// Backpressure: none.
// Ports: instr (32b instruction word in), imm (32b shaped immediate out; 0 for non-immediate opcodes).
module cayde_imm_gen
   import cayde_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   logic [2:0] f3;
   assign f3 = instr[14:12];

   always_comb begin
      imm = 32'h0;
      case (instr[6:0])
         OPC_OP_IMM: begin
            // Shifts carry shamt in the low immediate bits; funct7 is not part of the value.
            if (f3 == 3'b001 || f3 == 3'b101) imm = {27'b0, instr[24:20]};
            else                              imm = {{20{instr[31]}}, instr[31:20]};
         end
         OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
         default:            imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/cayde_alu_decode.sv
// Decode stage: RV32I OP/OP-IMM/LUI/AUIPC into a registered bundle for cayde_alu; counts illegal bundles.
// Latency: 1 cycle from accept to dec_valid_o.
// Backpressure: instr_ready_o = !flush_i && (!dec_valid_o || dec_ready_i); payload held while stalled.
// Ports: clk_i/rst_ni; flush_i; fetch side instr_valid_i/instr_ready_o/instr_i/pc_i;
//        execute side dec_valid_o/dec_ready_i plus alu_op_o, rs1/rs2/rd_addr_o, imm_o,
//        sel_imm_o/sel_pc_o/sel_zero_o, we_o, illegal_o, pc_o; illegal_cnt_o (saturating).
module cayde_alu_decode
   import cayde_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             instr_valid_i,
   output logic             instr_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [31:0]      pc_i,
   output logic             dec_valid_o,
   input  logic             dec_ready_i,
   output alu_op_e          alu_op_o,
   output logic [4:0]       rs1_addr_o,
   output logic [4:0]       rs2_addr_o,
   output logic [4:0]       rd_addr_o,
   output logic [31:0]      imm_o,
   output logic             sel_imm_o,
   output logic             sel_pc_o,
   output logic             sel_zero_o,
   output logic             we_o,
   output logic             illegal_o,
   output logic [31:0]      pc_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_raw;
   logic        legal;
   dec_bundle_t dec;
   dec_bundle_t dec_q;
   logic        valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic        accept;
   logic        out_hs;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   cayde_imm_gen u_imm_gen (
      .instr (instr_i),
      .imm   (imm_raw)
   );

   always_comb begin
      legal        = 1'b0;
      dec          = '0;
      dec.alu_op   = ALU_ADD;
      dec.rd_addr  = instr_i[11:7];
      dec.pc       = pc_i;
      case (opc)
         OPC_OP: begin
            dec.rs1_addr = instr_i[19:15];
            dec.rs2_addr = instr_i[24:20];
            if (f7 == F7_BASE) begin
               legal      = 1'b1;
               dec.alu_op = f3_to_op(f3);
            end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
               legal      = 1'b1;
               dec.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            dec.rs1_addr = instr_i[19:15];
            dec.sel_imm  = 1'b1;
            case (f3)
               3'b001: begin
                  legal      = (f7 == F7_BASE);
                  dec.alu_op = ALU_SLL;
               end
               3'b101: begin
                  legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
                  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               end
               default: begin
                  legal      = 1'b1;
                  dec.alu_op = f3_to_op(f3);
               end
            endcase
         end
         OPC_LUI: begin
            legal        = 1'b1;
            dec.sel_zero = 1'b1;
            dec.sel_imm  = 1'b1;
         end
         OPC_AUIPC: begin
            legal       = 1'b1;
            dec.sel_pc  = 1'b1;
            dec.sel_imm = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      dec.imm = imm_raw;
      // Illegal bundles still travel to execute (which traps) but must be side-effect free.
      if (!legal) begin
         dec.alu_op   = ALU_ADD;
         dec.sel_imm  = 1'b0;
         dec.sel_pc   = 1'b0;
         dec.sel_zero = 1'b0;
         dec.imm      = 32'h0;
      end
      dec.illegal = !legal;
      dec.we      = legal && (instr_i[11:7] != 5'd0);
   end

   assign instr_ready_o = !flush_i && (!valid_q || dec_ready_i);
   assign accept        = instr_valid_i && instr_ready_o;
   assign out_hs        = valid_q && dec_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // A flushed bundle never counts as delivered, even if execute was ready.
         if (out_hs && !flush_i && dec_q.illegal && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_ONE;
         if (flush_i)     valid_q <= 1'b0;
         else if (accept) valid_q <= 1'b1;
         else if (out_hs) valid_q <= 1'b0;
         if (accept) dec_q <= dec;
      end
   end

   assign dec_valid_o   = valid_q;
   assign alu_op_o      = dec_q.alu_op;
   assign rs1_addr_o    = dec_q.rs1_addr;
   assign rs2_addr_o    = dec_q.rs2_addr;
   assign rd_addr_o     = dec_q.rd_addr;
   assign imm_o         = dec_q.imm;
   assign sel_imm_o     = dec_q.sel_imm;
   assign sel_pc_o      = dec_q.sel_pc;
   assign sel_zero_o    = dec_q.sel_zero;
   assign we_o          = dec_q.we;
   assign illegal_o     = dec_q.illegal;
   assign pc_o          = dec_q.pc;
   assign illegal_cnt_o = cnt_q;

endmodule
